ser_4b5b: RTL and testbench

Transmit-side counterpart to the deser400 receive path. Accepts 4-bit nibbles (or a sync request) through a valid/ready handshake and buffers them in a small FIFO. Each nibble is 4b/5b encoded, serialized MSB-first and optionally NRZI encoded onto a single serial line at one bit per enabled clk160 cycle. Used for loopback self-test of the deser chain and as an emulated ROC/TBM data source.

---
 rtl/deser_pkg.sv | 32 +++
 rtl/ser_fifo.sv | 54 +++++
 rtl/ser_4b5b.sv | 83 ++++++++
 tb/tb_ser_4b5b.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants and the 4b/5b encoder for the ser/deser data path.
package deser_pkg;

  localparam int unsigned SYM_W = 5;

  localparam logic [SYM_W-1:0] IDLE_SYM_C = 5'b11111;
  localparam logic [SYM_W-1:0] SYNC_SYM_C = 5'b11000;

  function automatic logic [SYM_W-1:0] enc4b5b(input logic [3:0] nib);
    logic [SYM_W-1:0] sym;
    case (nib)
      4'h0:    sym = 5'b11110;
      4'h1:    sym = 5'b01001;
      4'h2:    sym = 5'b10100;
      4'h3:    sym = 5'b10101;
      4'h4:    sym = 5'b01010;
      4'h5:    sym = 5'b01011;
      4'h6:    sym = 5'b01110;
      4'h7:    sym = 5'b01111;
      4'h8:    sym = 5'b10010;
      4'h9:    sym = 5'b10011;
      4'hA:    sym = 5'b10110;
      4'hB:    sym = 5'b10111;
      4'hC:    sym = 5'b11010;
      4'hD:    sym = 5'b11011;
      4'hE:    sym = 5'b11100;
      default: sym = 5'b11101;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/ser_fifo.sv
// Small synchronous FIFO holding {ctrl, nibble} entries for the serializer.
module ser_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                       clk160,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk160) begin
    if (push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk160) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ser_4b5b.sv
// 4b/5b serializer: buffers nibbles, encodes, shifts out MSB-first with optional NRZI.
module ser_4b5b
  import deser_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter bit               NRZI_EN    = 1'b1,
  parameter logic [SYM_W-1:0] IDLE_SYM   = IDLE_SYM_C,
  parameter logic [SYM_W-1:0] SYNC_SYM   = SYNC_SYM_C
) (
  input  logic                          clk160,
  input  logic                          reset,
  input  logic                          ena,
  input  logic [3:0]                    din,
  input  logic                          din_ctrl,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          sdata,
  output logic                          sym_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [SYM_W-1:0] sh;
  logic [SYM_W-1:0] sh_next;
  logic [2:0]       cnt;
  logic             line;
  logic             load_d;
  logic             boundary;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SYM_W-1:0] fifo_rdata;
  logic             push;
  logic             pop;

  assign din_ready = !fifo_full && !reset;
  assign push      = din_valid && din_ready;
  assign boundary  = (cnt == 3'd4);
  assign pop       = ena && boundary && !fifo_empty;
  assign sdata     = line;

  ser_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SYM_W)
  ) u_fifo (
    .clk160 (clk160),
    .reset  (reset),
    .push   (push),
    .wdata  ({din_ctrl, din}),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Bit 4 of a FIFO entry is the ctrl flag; an empty FIFO at a boundary sends idle.
  always_comb begin
    sh_next = {sh[SYM_W-2:0], 1'b0};
    if (boundary) begin
      if (fifo_empty)          sh_next = IDLE_SYM;
      else if (fifo_rdata[4])  sh_next = SYNC_SYM;
      else                     sh_next = enc4b5b(fifo_rdata[3:0]);
    end
  end

  always_ff @(posedge clk160) begin
    if (reset) begin
      sh         <= IDLE_SYM;
      cnt        <= '0;
      line       <= 1'b0;
      load_d     <= 1'b0;
      sym_strobe <= 1'b0;
    end else if (ena) begin
      line       <= NRZI_EN ? (line ^ sh[SYM_W-1]) : sh[SYM_W-1];
      sh         <= sh_next;
      cnt        <= boundary ? 3'd0 : cnt + 3'd1;
      sym_strobe <= load_d;
      load_d     <= boundary;
    end else begin
      sym_strobe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ser_4b5b.sv
// Bench for ser_4b5b: NRZ and NRZI instances checked against a bit-stream reference model.
module tb_ser_4b5b;

  localparam int unsigned DEPTH = 4;

  logic       clk160 = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic [3:0] din = 4'h0;
  logic       din_ctrl = 1'b0;
  logic       din_valid = 1'b0;

  logic       ready_a, ready_b, sdata_a, sdata_b, strobe_a, strobe_b;
  logic [2:0] level_a, level_b;

  always #5 clk160 = ~clk160;

  ser_4b5b #(.FIFO_DEPTH(DEPTH), .NRZI_EN(1'b0)) dut_nrz (
    .clk160     (clk160),
    .reset      (reset),
    .ena        (ena),
    .din        (din),
    .din_ctrl   (din_ctrl),
    .din_valid  (din_valid),
    .din_ready  (ready_a),
    .sdata      (sdata_a),
    .sym_strobe (strobe_a),
    .fifo_level (level_a)
  );

  ser_4b5b #(.FIFO_DEPTH(DEPTH), .NRZI_EN(1'b1)) dut_nrzi (
    .clk160     (clk160),
    .reset      (reset),
    .ena        (ena),
    .din        (din),
    .din_ctrl   (din_ctrl),
    .din_valid  (din_valid),
    .din_ready  (ready_b),
    .sdata      (sdata_b),
    .sym_strobe (strobe_b),
    .fifo_level (level_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending line bits as a queue, refilled one whole symbol at a time.
  bit [4:0] enc_tab [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                             5'b01010, 5'b01011, 5'b01110, 5'b01111,
                             5'b10010, 5'b10011, 5'b10110, 5'b10111,
                             5'b11010, 5'b11011, 5'b11100, 5'b11101};
  bit [4:0] m_fifo [$];
  bit       m_bits [$];
  bit       m_first [$];
  bit       m_nrz, m_nrzi, m_strobe;

  function automatic void load_sym(input bit [4:0] s, input bit marked);
    for (int i = 4; i >= 0; i--) begin
      m_bits.push_back(s[i]);
      m_first.push_back(marked && (i == 4));
    end
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_bits.delete();
    m_first.delete();
    load_sym(5'b11111, 1'b0);
    m_nrz = 1'b0;
    m_nrzi = 1'b0;
    m_strobe = 1'b0;
  endfunction

  function automatic bit model_ready(input bit r);
    return !r && (m_fifo.size() < DEPTH);
  endfunction

  function automatic void model_edge(input bit r, input bit e, input bit v, input bit c,
                                     input bit [3:0] d);
    bit b, f, push_ok;
    bit [4:0] s;
    if (r) begin
      model_reset();
      return;
    end
    push_ok = v && model_ready(1'b0);
    if (e) begin
      b = m_bits.pop_front();
      f = m_first.pop_front();
      if (m_bits.size() == 0) begin
        if (m_fifo.size() > 0) begin
          s = m_fifo.pop_front();
          load_sym(s[4] ? 5'b11000 : enc_tab[s[3:0]], 1'b1);
        end else begin
          load_sym(5'b11111, 1'b1);
        end
      end
      m_nrz = b;
      m_nrzi = m_nrzi ^ b;
      m_strobe = f;
    end else begin
      m_strobe = 1'b0;
    end
    if (push_ok) m_fifo.push_back({c, d});
  endfunction

  // Called at a falling edge: drive, check ready, clock, check outputs at the next falling edge.
  task automatic cycle(input bit r, input bit e, input bit v, input bit c, input bit [3:0] d);
    reset = r;
    ena = e;
    din_valid = v;
    din_ctrl = c;
    din = d;
    #1;
    check("din_ready_nrz", 32'(ready_a), 32'(model_ready(r)));
    check("din_ready_nrzi", 32'(ready_b), 32'(model_ready(r)));
    @(posedge clk160);
    model_edge(r, e, v, c, d);
    @(negedge clk160);
    check("sdata_nrz", 32'(sdata_a), 32'(m_nrz));
    check("sdata_nrzi", 32'(sdata_b), 32'(m_nrzi));
    check("strobe_nrz", 32'(strobe_a), 32'(m_strobe));
    check("strobe_nrzi", 32'(strobe_b), 32'(m_strobe));
    check("level_nrz", 32'(level_a), 32'(m_fifo.size()));
    check("level_nrzi", 32'(level_b), 32'(m_fifo.size()));
  endtask

  initial begin
    bit [3:0] nib;
    bit       en;
    int       guard;
    model_reset();
    @(negedge clk160);

    repeat (2) cycle(1, 0, 0, 0, 4'h0);
    // Idle line after reset
    repeat (20) cycle(0, 1, 0, 0, 4'h0);
    // Single data nibble 0
    cycle(0, 1, 1, 0, 4'h0);
    repeat (15) cycle(0, 1, 0, 0, 4'h0);
    // Sync request, nibble ignored
    cycle(0, 1, 1, 1, 4'hA);
    repeat (15) cycle(0, 1, 0, 0, 4'h0);
    // Five pushes with the line stalled: the fifth is dropped
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 4'(i + 1));
    check("level_full", 32'(level_a), 32'(DEPTH));
    repeat (30) cycle(0, 1, 0, 0, 4'h0);

    // Back-to-back stream 0..F with ena toggling
    nib = 4'h0;
    en = 1'b0;
    guard = 0;
    while (guard < 300) begin
      bit acc;
      en = !en;
      acc = model_ready(1'b0);
      cycle(0, en, 1, 0, nib);
      guard++;
      if (acc) begin
        if (nib == 4'hF) break;
        nib = nib + 4'h1;
      end
    end
    check("stream_pushed", 32'(guard < 300), 32'(1));
    for (int i = 0; i < 100; i++) cycle(0, (i % 2) == 0, 0, 0, 4'h0);

    // Reset in the middle of a data symbol with words queued
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 4'(i + 5));
    repeat (7) cycle(0, 1, 0, 0, 4'h0);
    cycle(1, 1, 0, 0, 4'h0);
    check("reset_sdata", 32'(sdata_a), 32'(0));
    check("reset_level", 32'(level_a), 32'(0));
    repeat (20) cycle(0, 1, 0, 0, 4'h0);

    // Randomized traffic with occasional resets
    repeat (3000) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
